// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port, IF/ID register out.
interface fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus1;
  logic        id_valid;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_instr,
    output imem_addr, id_instr, id_pc_plus1, id_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  imem_addr, id_instr, id_pc_plus1, id_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-flight address tracking across the one-cycle memory
// latency, stall hold, redirect flush, and the IF/ID pipeline register.
module fetch_unit #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_pc_d;
  logic          r_f1_valid;
  logic [31:0]   r_id_instr;
  logic [AW-1:0] r_id_pc_plus1;
  logic          r_id_valid;

  logic          w_redirect;
  logic [31:0]   w_pc32;
  logic [31:0]   w_jump_addr;
  logic [31:0]   w_target;

  assign w_redirect  = bus.branch_taken | bus.jump;
  assign w_pc32      = 32'(r_pc);
  assign w_jump_addr = {6'(w_pc32 >> 26), bus.jump_target};
  assign w_target    = bus.branch_taken ? bus.branch_target : w_jump_addr;

  // During a plain stall re-issue the in-flight address so its data stays on imem_instr.
  assign bus.imem_addr = (bus.stall && !w_redirect) ? 32'(r_pc_d) : 32'(r_pc);

  assign bus.id_instr    = r_id_instr;
  assign bus.id_pc_plus1 = 32'(r_id_pc_plus1);
  assign bus.id_valid    = r_id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= AW'(RESET_PC);
      r_pc_d        <= '0;
      r_f1_valid    <= 1'b0;
      r_id_instr    <= '0;
      r_id_pc_plus1 <= '0;
      r_id_valid    <= 1'b0;
    end else if (w_redirect) begin
      // Redirect beats stall; the word already in flight is wrong-path.
      r_pc          <= AW'(w_target);
      r_f1_valid    <= 1'b0;
      r_id_instr    <= '0;
      r_id_pc_plus1 <= '0;
      r_id_valid    <= 1'b0;
    end else if (!bus.stall) begin
      if (r_f1_valid) begin
        r_id_instr    <= bus.imem_instr;
        r_id_pc_plus1 <= r_pc_d + AW'(1);
        r_id_valid    <= 1'b1;
      end else begin
        r_id_instr    <= '0;
        r_id_pc_plus1 <= '0;
        r_id_valid    <= 1'b0;
      end
      r_pc_d     <= r_pc;
      r_f1_valid <= 1'b1;
      r_pc       <= r_pc + AW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-edge vectors plus reset/wrap sequences.
module tb_fetch_unit;

  logic clk;
  logic rst0;
  logic rst1;

  fetch_unit_if bus0();
  fetch_unit_if bus1();

  fetch_unit #(.MEM_DEPTH(1024), .RESET_PC(0))    u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  fetch_unit #(.MEM_DEPTH(1024), .RESET_PC(1022)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [31:0] w;
    w = {16'hC0DE, 6'd0, a[9:0]};
    return w;
  endfunction

  // Registered-read instruction memories
  always @(posedge clk) bus0.imem_instr <= mw(bus0.imem_addr);
  always @(posedge clk) bus1.imem_instr <= mw(bus1.imem_addr);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc1;
  } vec_t;

  int n_vec;
  int n_err;

  function automatic vec_t mk(input logic s, input logic b, input int bt, input logic j,
                              input int jt, input int addr, input logic v, input int ia,
                              input int p1);
    vec_t r;
    r.stall   = s;
    r.br      = b;
    r.bt      = 32'(bt);
    r.jmp     = j;
    r.jt      = 26'(jt);
    r.e_addr  = 32'(addr);
    r.e_valid = v;
    r.e_instr = v ? mw(32'(ia)) : 32'd0;
    r.e_pc1   = v ? 32'(p1) : 32'd0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_id0(input string nm, input logic v, input logic [31:0] ins,
                         input logic [31:0] p1);
    chk({nm, ".valid"}, 32'(bus0.id_valid), 32'(v));
    chk({nm, ".instr"}, bus0.id_instr, ins);
    chk({nm, ".pc1"}, bus0.id_pc_plus1, p1);
  endtask

  task automatic chk_id1(input string nm, input logic v, input logic [31:0] ins,
                         input logic [31:0] p1);
    chk({nm, ".valid"}, 32'(bus1.id_valid), 32'(v));
    chk({nm, ".instr"}, bus1.id_instr, ins);
    chk({nm, ".pc1"}, bus1.id_pc_plus1, p1);
  endtask

  task automatic drive0(input logic s, input logic b, input logic [31:0] bt, input logic j,
                        input logic [25:0] jt);
    bus0.stall = s; bus0.branch_taken = b; bus0.branch_target = bt;
    bus0.jump = j; bus0.jump_target = jt;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[35];

  initial begin
    n_vec = 0;
    n_err = 0;

    // row: stall, br, br_tgt, jmp, jmp_tgt, expected imem_addr, id_valid, instr addr, pc+1
    tbl[0]  = mk(0, 0, 0,    0, 0,    0,    0, 0,    0);
    tbl[1]  = mk(0, 0, 0,    0, 0,    1,    1, 0,    1);
    tbl[2]  = mk(0, 0, 0,    0, 0,    2,    1, 1,    2);
    tbl[3]  = mk(1, 0, 0,    0, 0,    2,    1, 1,    2);
    tbl[4]  = mk(1, 0, 0,    0, 0,    2,    1, 1,    2);
    tbl[5]  = mk(1, 0, 0,    0, 0,    2,    1, 1,    2);
    tbl[6]  = mk(0, 0, 0,    0, 0,    3,    1, 2,    3);
    tbl[7]  = mk(0, 0, 0,    0, 0,    4,    1, 3,    4);
    tbl[8]  = mk(0, 1, 14,   0, 0,    5,    0, 0,    0);
    tbl[9]  = mk(0, 0, 0,    0, 0,    14,   0, 0,    0);
    tbl[10] = mk(0, 0, 0,    0, 0,    15,   1, 14,   15);
    tbl[11] = mk(0, 0, 0,    0, 0,    16,   1, 15,   16);
    tbl[12] = mk(0, 0, 0,    1, 5,    17,   0, 0,    0);
    tbl[13] = mk(0, 0, 0,    0, 0,    5,    0, 0,    0);
    tbl[14] = mk(0, 0, 0,    0, 0,    6,    1, 5,    6);
    tbl[15] = mk(0, 1, 9,    1, 5,    7,    0, 0,    0);
    tbl[16] = mk(0, 0, 0,    0, 0,    9,    0, 0,    0);
    tbl[17] = mk(0, 0, 0,    0, 0,    10,   1, 9,    10);
    tbl[18] = mk(1, 1, 20,   0, 0,    11,   0, 0,    0);
    tbl[19] = mk(0, 0, 0,    0, 0,    20,   0, 0,    0);
    tbl[20] = mk(0, 0, 0,    0, 0,    21,   1, 20,   21);
    tbl[21] = mk(0, 1, 40,   0, 0,    22,   0, 0,    0);
    tbl[22] = mk(0, 0, 0,    1, 60,   40,   0, 0,    0);
    tbl[23] = mk(0, 0, 0,    0, 0,    60,   0, 0,    0);
    tbl[24] = mk(0, 0, 0,    0, 0,    61,   1, 60,   61);
    tbl[25] = mk(0, 0, 0,    0, 0,    62,   1, 61,   62);
    tbl[26] = mk(1, 0, 0,    0, 0,    62,   1, 61,   62);
    tbl[27] = mk(0, 0, 0,    0, 0,    63,   1, 62,   63);
    tbl[28] = mk(0, 1, 1031, 0, 0,    64,   0, 0,    0);
    tbl[29] = mk(0, 0, 0,    0, 0,    7,    0, 0,    0);
    tbl[30] = mk(0, 0, 0,    0, 0,    8,    1, 7,    8);
    tbl[31] = mk(0, 0, 0,    1, 3071, 9,    0, 0,    0);
    tbl[32] = mk(0, 0, 0,    0, 0,    1023, 0, 0,    0);
    tbl[33] = mk(0, 0, 0,    0, 0,    0,    1, 1023, 0);
    tbl[34] = mk(0, 0, 0,    0, 0,    1,    1, 0,    1);

    rst0 = 1'b1;
    rst1 = 1'b1;
    drive0(0, 0, 32'd0, 0, 26'd0);
    bus1.stall = 1'b0; bus1.branch_taken = 1'b0; bus1.branch_target = '0;
    bus1.jump = 1'b0; bus1.jump_target = '0;
    edge1();
    edge1();
    chk_id0("reset0", 1'b0, 32'd0, 32'd0);

    rst0 = 1'b0;
    for (int i = 0; i < 35; i++) begin
      drive0(tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt);
      #1;
      chk($sformatf("row%0d.addr", i), bus0.imem_addr, tbl[i].e_addr);
      edge1();
      chk_id0($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc1);
    end

    // Reset wins over a simultaneous stall and branch
    rst0 = 1'b1;
    drive0(1, 1, 32'd50, 1, 26'd70);
    edge1();
    chk_id0("rst_redir", 1'b0, 32'd0, 32'd0);
    drive0(0, 0, 32'd0, 0, 26'd0);
    #1;
    chk("rst_redir.addr", bus0.imem_addr, 32'd0);
    rst0 = 1'b0;
    edge1();
    chk_id0("rst_redir.e1", 1'b0, 32'd0, 32'd0);
    edge1();
    chk_id0("rst_redir.e2", 1'b1, mw(32'd0), 32'd1);

    // Second instance: wrap from RESET_PC=1022, then reset during a stall
    #1;
    chk("wrap.addr0", bus1.imem_addr, 32'd1022);
    rst1 = 1'b0;
    edge1();
    chk_id1("wrap.e1", 1'b0, 32'd0, 32'd0);
    edge1();
    chk_id1("wrap.e2", 1'b1, mw(32'd1022), 32'd1023);
    edge1();
    chk_id1("wrap.e3", 1'b1, mw(32'd1023), 32'd0);
    edge1();
    chk_id1("wrap.e4", 1'b1, mw(32'd0), 32'd1);
    bus1.stall = 1'b1;
    #1;
    chk("wrap.stall_addr", bus1.imem_addr, 32'd1);
    edge1();
    chk_id1("wrap.stall", 1'b1, mw(32'd0), 32'd1);
    rst1 = 1'b1;
    edge1();
    chk_id1("wrap.rst", 1'b0, 32'd0, 32'd0);
    bus1.stall = 1'b0;
    #1;
    chk("wrap.rst_addr", bus1.imem_addr, 32'd1022);
    rst1 = 1'b0;
    edge1();
    chk_id1("wrap.re1", 1'b0, 32'd0, 32'd0);
    edge1();
    chk_id1("wrap.re2", 1'b1, mw(32'd1022), 32'd1023);
    edge1();
    chk_id1("wrap.re3", 1'b1, mw(32'd1023), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
